// File: rtl/sign_extend_pkg.sv
// Shared rv32i immediate-generation constants and per-format extraction helpers.
// The control decoder imports the same format encodings.
package sign_extend_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int SRC_WIDTH   = 25;
    localparam int IMM_WIDTH   = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_fmt_e;

    // Each helper receives instr[31:7] as s, so instr[n] == s[n-7].
    function automatic logic [IMM_WIDTH-1:0] imm_i(input logic [SRC_WIDTH-1:0] s);
        return {{20{s[24]}}, s[24:13]};
    endfunction

    function automatic logic [IMM_WIDTH-1:0] imm_s(input logic [SRC_WIDTH-1:0] s);
        return {{20{s[24]}}, s[24:18], s[4:0]};
    endfunction

    function automatic logic [IMM_WIDTH-1:0] imm_b(input logic [SRC_WIDTH-1:0] s);
        return {{19{s[24]}}, s[24], s[0], s[23:18], s[4:1], 1'b0};
    endfunction

    function automatic logic [IMM_WIDTH-1:0] imm_j(input logic [SRC_WIDTH-1:0] s);
        return {{11{s[24]}}, s[24], s[12:5], s[13], s[23:14], 1'b0};
    endfunction

    function automatic logic [IMM_WIDTH-1:0] imm_u(input logic [SRC_WIDTH-1:0] s);
        return {s[24:5], 12'b0};
    endfunction

endpackage

// File: rtl/sign_extend.sv
// rv32i immediate generator: combinational sign-extended immediate plus an
// enable-gated registered copy for multi-cycle consumers.
module sign_extend
    import sign_extend_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SRC_WIDTH-1:0] src,
    input  logic [2:0]           imm_src,
    input  logic                 en,
    output logic [XLEN-1:0]      imm_signed,
    output logic [XLEN-1:0]      imm_signed_q
);

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] r_imm_q;

    // NOTE: w_imm gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_imm = '0;
        case (imm_src)
            IMM_I:   w_imm = imm_i(src);
            IMM_S:   w_imm = imm_s(src);
            IMM_B:   w_imm = imm_b(src);
            IMM_J:   w_imm = imm_j(src);
            IMM_U:   w_imm = imm_u(src);
            default: w_imm = '0;  // reserved selects yield zero
        endcase
    end

    // NOTE: state is updated with non-blocking assignments and cleared by the
    // asynchronous reset, so the copy reads zero as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imm_q <= '0;
        end else if (en) begin
            r_imm_q <= w_imm;
        end
    end

    assign imm_signed   = w_imm;
    assign imm_signed_q = r_imm_q;

endmodule

// File: tb/tb_sign_extend.sv
// Directed checks of the rv32i immediate generator: a vector table for the
// combinational path and hand-written sequences for the registered copy.
module tb_sign_extend;

    logic        clk;
    logic        rst;
    logic [24:0] src;
    logic [2:0]  imm_src;
    logic        en;
    logic [31:0] imm_signed;
    logic [31:0] imm_signed_q;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [31:0] exp;
    } vec_t;

    sign_extend #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .src          (src),
        .imm_src      (imm_src),
        .en           (en),
        .imm_signed   (imm_signed),
        .imm_signed_q (imm_signed_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [2:0] sel);
        src     = instr[31:7];
        imm_src = sel;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"i_pos",      32'h12300093, 3'b000, 32'h00000123});
        vecs.push_back('{"i_zero",     32'h00000093, 3'b000, 32'h00000000});
        vecs.push_back('{"i_neg",      32'hF0000093, 3'b000, 32'hFFFFFF00});
        vecs.push_back('{"i_maxpos",   32'h7FF00013, 3'b000, 32'h000007FF});
        vecs.push_back('{"s_pos",      32'h122021A3, 3'b001, 32'h00000123});
        vecs.push_back('{"s_neg",      32'hFE202E23, 3'b001, 32'hFFFFFFFC});
        vecs.push_back('{"b_pos",      32'h10000063, 3'b010, 32'h00000100});
        vecs.push_back('{"b_neg",      32'hFE000EE3, 3'b010, 32'hFFFFFFFC});
        vecs.push_back('{"j_pos",      32'h0000106F, 3'b011, 32'h00001000});
        vecs.push_back('{"j_neg",      32'hFFDFF06F, 3'b011, 32'hFFFFFFFC});
        vecs.push_back('{"u_lui",      32'h00200137, 3'b100, 32'h00200000});
        vecs.push_back('{"u_ones",     32'hFFFFF037, 3'b100, 32'hFFFFF000});
        vecs.push_back('{"rsv_101",    32'hFFFFFFFF, 3'b101, 32'h00000000});
        vecs.push_back('{"rsv_110",    32'hFFFFFFFF, 3'b110, 32'h00000000});
        vecs.push_back('{"rsv_111",    32'h12300093, 3'b111, 32'h00000000});

        // Async reset: registered copy must be zero before any clock edge.
        rst = 1'b1;
        en  = 1'b1;
        drive(32'h12300093, 3'b000);
        #2;
        check("q_reset_no_edge", imm_signed_q, 32'h00000000);
        check("comb_during_reset", imm_signed, 32'h00000123);

        // Combinational table; reset held so the register cannot change.
        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].sel);
            #1;
            check(vecs[i].name, imm_signed, vecs[i].exp);
        end
        check("q_held_in_reset", imm_signed_q, 32'h00000000);

        // Release reset away from an edge; load happens on the next edge.
        @(negedge clk);
        drive(32'h12300093, 3'b000);
        en  = 1'b1;
        rst = 1'b0;
        #1;
        check("q_before_first_edge", imm_signed_q, 32'h00000000);
        @(posedge clk); #1;
        check("q_load_i123", imm_signed_q, 32'h00000123);

        // Hold with en=0 while the input changes.
        @(negedge clk);
        en = 1'b0;
        drive(32'hF0000093, 3'b000);
        @(posedge clk); #1;
        check("q_hold_en0", imm_signed_q, 32'h00000123);
        check("comb_follows_en0", imm_signed, 32'hFFFFFF00);
        @(posedge clk); #1;
        check("q_hold_en0_2", imm_signed_q, 32'h00000123);

        // Re-enable: loads the new value.
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("q_load_neg", imm_signed_q, 32'hFFFFFF00);

        // Mid-cycle reset clears at once, regardless of en.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("q_async_clear", imm_signed_q, 32'h00000000);

        // Release with en=0: stays zero across an edge.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        drive(32'h00200137, 3'b100);
        @(posedge clk); #1;
        check("q_hold_after_reset", imm_signed_q, 32'h00000000);

        // Load a U-type value.
        @(negedge clk);
        en = 1'b1;
        @(posedge clk); #1;
        check("q_load_u", imm_signed_q, 32'h00200000);

        // Reserved select loads zero.
        @(negedge clk);
        drive(32'hFFFFFFFF, 3'b110);
        @(posedge clk); #1;
        check("q_load_reserved", imm_signed_q, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
